// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard scan controller.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ESC   = 8'h76;

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data into the clk domain and flags PS/2 clock falling edges.
module ps2_sync_edge
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;

    // Reset to the idle bus level so no spurious edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data;
            data_s2_q  <= data_s1_q;
        end
    end

    assign data_s = data_s2_q;
    assign fall   = clk_prev_q & ~clk_s2_q;

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 keyboard frame receiver with E0/F0 prefix decoding, a valid/ready event output
// and held-level tracking for the space and esc keys.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       space_held,
    output logic       esc_held,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES - 1);

    logic           data_s;
    logic           fall;
    ps2_state_e     state_q;
    logic [2:0]     cnt_q;
    logic [7:0]     shift_q;
    logic           parity_ok_q;
    logic           ext_pend_q;
    logic           brk_pend_q;
    logic [WdW-1:0] wd_q;
    logic           byte_good;
    logic           evt;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (PS2_clk),
        .ps2_data (PS2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    always_comb begin
        byte_good = fall && (state_q == StStop) && data_s && parity_ok_q;
        evt       = byte_good && (shift_q != PS2_EXT) && (shift_q != PS2_BREAK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            wd_q        <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_break   <= 1'b0;
            key_ext     <= 1'b0;
            space_held  <= 1'b0;
            esc_held    <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;

            if (key_valid && key_ready) key_valid <= 1'b0;

            if (evt) begin
                // A concurrent transfer frees the register; otherwise the held event wins.
                if (!key_valid || key_ready) begin
                    key_valid <= 1'b1;
                    key_code  <= shift_q;
                    key_break <= brk_pend_q;
                    key_ext   <= ext_pend_q;
                end else begin
                    overflow <= 1'b1;
                end
                if (!ext_pend_q && shift_q == KEY_SPACE) space_held <= ~brk_pend_q;
                if (!ext_pend_q && shift_q == KEY_ESC)   esc_held   <= ~brk_pend_q;
            end

            if (fall) begin
                wd_q <= '0;
                case (state_q)
                    StIdle: begin
                        if (!data_s) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    StData: begin
                        shift_q <= {data_s, shift_q[7:1]};
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_q <= StParity;
                    end
                    StParity: begin
                        parity_ok_q <= ^{shift_q, data_s};
                        state_q     <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (byte_good) begin
                            if (shift_q == PS2_EXT) begin
                                ext_pend_q <= 1'b1;
                            end else if (shift_q == PS2_BREAK) begin
                                brk_pend_q <= 1'b1;
                            end else begin
                                ext_pend_q <= 1'b0;
                                brk_pend_q <= 1'b0;
                            end
                        end else begin
                            frame_err  <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q != StIdle) begin
                // PS/2 clock stalled mid-frame: abandon the byte and any prefixes.
                if (wd_q == WdMax) begin
                    state_q    <= StIdle;
                    frame_err  <= 1'b1;
                    shift_q    <= '0;
                    cnt_q      <= '0;
                    ext_pend_q <= 1'b0;
                    brk_pend_q <= 1'b0;
                    wd_q       <= '0;
                end else begin
                    wd_q <= wd_q + WdW'(1);
                end
            end else begin
                wd_q <= '0;
            end
        end
    end

endmodule
